// File: rtl/decode_queue_pkg.sv
// Shared definitions for the decode queue: operation codes, RV32I opcode
// constants and the basic datapath types used by the queue and the decoder.
package decode_queue_pkg;

    localparam int DQ_XLEN = 32;
    localparam int OP_W    = 6;

    // Major opcodes (inst[6:0]) of the RV32I base ISA.
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef logic [DQ_XLEN-1:0] INST_TYPE;
    typedef logic [4:0]         REG_ID_TYPE;
    typedef logic [DQ_XLEN-1:0] IMM_TYPE;

    // Decoded operation; NOP_INST doubles as the code for illegal words.
    typedef enum logic [OP_W-1:0] {
        NOP_INST = 6'd0,
        LUI_INST, AUIPC_INST, JAL_INST, JALR_INST,
        BEQ_INST, BNE_INST, BLT_INST, BGE_INST, BLTU_INST, BGEU_INST,
        LB_INST, LH_INST, LW_INST, LBU_INST, LHU_INST,
        SB_INST, SH_INST, SW_INST,
        ADDI_INST, SLTI_INST, SLTIU_INST, XORI_INST, ORI_INST, ANDI_INST,
        SLLI_INST, SRLI_INST, SRAI_INST,
        ADD_INST, SUB_INST, SLL_INST, SLT_INST, SLTU_INST,
        XOR_INST, SRL_INST, SRA_INST, OR_INST, AND_INST,
        FENCE_INST, ECALL_INST, EBREAK_INST
    } op_e;

endpackage

// File: rtl/decode_queue_if.sv
// Fetcher-side push handshake and dispatch-side decoded output slot.
interface decode_queue_if;
    import decode_queue_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DQ_XLEN-1:0]   in_inst;
    logic [DQ_XLEN-1:0]   in_pc;

    logic                 out_valid;
    logic                 out_ready;
    op_e                  out_op;
    logic [4:0]           out_rd;
    logic [4:0]           out_rs1;
    logic [4:0]           out_rs2;
    logic [DQ_XLEN-1:0]   out_imm;
    logic [DQ_XLEN-1:0]   out_pc;
    logic                 out_is_ls;
    logic                 out_is_store;
    logic                 out_is_branch;
    logic                 out_illegal;

    // Queue side.
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_is_ls, out_is_store, out_is_branch,
               out_illegal
    );

    // Fetcher / dispatch side.
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_is_ls, out_is_store, out_is_branch,
               out_illegal
    );

endinterface

// File: rtl/decode_queue_rv32i_decode.sv
// Purely combinational RV32I decoder. Unused register ids are forced to zero
// and an undecodable word collapses to an all-zero NOP with illegal set.
module rv32i_decode
    import decode_queue_pkg::*;
(
    input  INST_TYPE   inst,
    output op_e        op,
    output REG_ID_TYPE rd,
    output REG_ID_TYPE rs1,
    output REG_ID_TYPE rs2,
    output IMM_TYPE    imm,
    output logic       is_ls,
    output logic       is_store,
    output logic       is_branch,
    output logic       illegal
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    REG_ID_TYPE rd_f_s;
    REG_ID_TYPE rs1_f_s;
    REG_ID_TYPE rs2_f_s;
    IMM_TYPE    i_imm_s;
    IMM_TYPE    s_imm_s;
    IMM_TYPE    b_imm_s;
    IMM_TYPE    u_imm_s;
    IMM_TYPE    j_imm_s;
    IMM_TYPE    shamt_s;

    op_e        raw_op_s;
    REG_ID_TYPE raw_rd_s;
    REG_ID_TYPE raw_rs1_s;
    REG_ID_TYPE raw_rs2_s;
    IMM_TYPE    raw_imm_s;
    logic       raw_is_ls_s;
    logic       raw_is_store_s;
    logic       raw_is_branch_s;
    logic       illegal_s;

    assign opcode_s = inst[6:0];
    assign rd_f_s   = inst[11:7];
    assign funct3_s = inst[14:12];
    assign rs1_f_s  = inst[19:15];
    assign rs2_f_s  = inst[24:20];
    assign funct7_s = inst[31:25];

    // Immediate formats; signed size casts provide the sign extension.
    assign i_imm_s = IMM_TYPE'($signed(inst[31:20]));
    assign s_imm_s = IMM_TYPE'($signed({inst[31:25], inst[11:7]}));
    assign b_imm_s = IMM_TYPE'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign u_imm_s = IMM_TYPE'($signed({inst[31:12], 12'h000}));
    assign j_imm_s = IMM_TYPE'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign shamt_s = IMM_TYPE'(inst[24:20]);

    // Opcode/funct decode into raw fields plus an illegal indication.
    always_comb begin
        raw_op_s        = NOP_INST;
        raw_rd_s        = 5'd0;
        raw_rs1_s       = 5'd0;
        raw_rs2_s       = 5'd0;
        raw_imm_s       = {DQ_XLEN{1'b0}};
        raw_is_ls_s     = 1'b0;
        raw_is_store_s  = 1'b0;
        raw_is_branch_s = 1'b0;
        illegal_s       = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                raw_op_s  = LUI_INST;
                raw_rd_s  = rd_f_s;
                raw_imm_s = u_imm_s;
            end
            OPC_AUIPC: begin
                raw_op_s  = AUIPC_INST;
                raw_rd_s  = rd_f_s;
                raw_imm_s = u_imm_s;
            end
            OPC_JAL: begin
                // All control transfers, direct jumps included, flag is_branch.
                raw_op_s        = JAL_INST;
                raw_rd_s        = rd_f_s;
                raw_imm_s       = j_imm_s;
                raw_is_branch_s = 1'b1;
            end
            OPC_JALR: begin
                raw_op_s        = JALR_INST;
                raw_rd_s        = rd_f_s;
                raw_rs1_s       = rs1_f_s;
                raw_imm_s       = i_imm_s;
                raw_is_branch_s = 1'b1;
                if (funct3_s != 3'b000) begin
                    illegal_s = 1'b1;
                end else begin
                    illegal_s = 1'b0;
                end
            end
            OPC_BRANCH: begin
                raw_rs1_s       = rs1_f_s;
                raw_rs2_s       = rs2_f_s;
                raw_imm_s       = b_imm_s;
                raw_is_branch_s = 1'b1;
                case (funct3_s)
                    3'b000:  raw_op_s  = BEQ_INST;
                    3'b001:  raw_op_s  = BNE_INST;
                    3'b100:  raw_op_s  = BLT_INST;
                    3'b101:  raw_op_s  = BGE_INST;
                    3'b110:  raw_op_s  = BLTU_INST;
                    3'b111:  raw_op_s  = BGEU_INST;
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                raw_rd_s    = rd_f_s;
                raw_rs1_s   = rs1_f_s;
                raw_imm_s   = i_imm_s;
                raw_is_ls_s = 1'b1;
                case (funct3_s)
                    3'b000:  raw_op_s  = LB_INST;
                    3'b001:  raw_op_s  = LH_INST;
                    3'b010:  raw_op_s  = LW_INST;
                    3'b100:  raw_op_s  = LBU_INST;
                    3'b101:  raw_op_s  = LHU_INST;
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_STORE: begin
                raw_rs1_s      = rs1_f_s;
                raw_rs2_s      = rs2_f_s;
                raw_imm_s      = s_imm_s;
                raw_is_ls_s    = 1'b1;
                raw_is_store_s = 1'b1;
                case (funct3_s)
                    3'b000:  raw_op_s  = SB_INST;
                    3'b001:  raw_op_s  = SH_INST;
                    3'b010:  raw_op_s  = SW_INST;
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                raw_rd_s  = rd_f_s;
                raw_rs1_s = rs1_f_s;
                raw_imm_s = i_imm_s;
                case (funct3_s)
                    3'b000: raw_op_s = ADDI_INST;
                    3'b010: raw_op_s = SLTI_INST;
                    3'b011: raw_op_s = SLTIU_INST;
                    3'b100: raw_op_s = XORI_INST;
                    3'b110: raw_op_s = ORI_INST;
                    3'b111: raw_op_s = ANDI_INST;
                    3'b001: begin
                        raw_imm_s = shamt_s;
                        if (funct7_s == F7_BASE) begin
                            raw_op_s = SLLI_INST;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    3'b101: begin
                        raw_imm_s = shamt_s;
                        case (funct7_s)
                            F7_BASE: raw_op_s  = SRLI_INST;
                            F7_ALT:  raw_op_s  = SRAI_INST;
                            default: illegal_s = 1'b1;
                        endcase
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_OP: begin
                raw_rd_s  = rd_f_s;
                raw_rs1_s = rs1_f_s;
                raw_rs2_s = rs2_f_s;
                case ({funct7_s, funct3_s})
                    {F7_BASE, 3'b000}: raw_op_s  = ADD_INST;
                    {F7_ALT,  3'b000}: raw_op_s  = SUB_INST;
                    {F7_BASE, 3'b001}: raw_op_s  = SLL_INST;
                    {F7_BASE, 3'b010}: raw_op_s  = SLT_INST;
                    {F7_BASE, 3'b011}: raw_op_s  = SLTU_INST;
                    {F7_BASE, 3'b100}: raw_op_s  = XOR_INST;
                    {F7_BASE, 3'b101}: raw_op_s  = SRL_INST;
                    {F7_ALT,  3'b101}: raw_op_s  = SRA_INST;
                    {F7_BASE, 3'b110}: raw_op_s  = OR_INST;
                    {F7_BASE, 3'b111}: raw_op_s  = AND_INST;
                    default:           illegal_s = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin
                // Ordering hints carry no operands downstream cares about.
                if (funct3_s == 3'b000) begin
                    raw_op_s = FENCE_INST;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                case (inst)
                    32'h0000_0073: raw_op_s  = ECALL_INST;
                    32'h0010_0073: raw_op_s  = EBREAK_INST;
                    default:       illegal_s = 1'b1;
                endcase
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Illegal words are squashed to an all-zero NOP so nothing downstream acts on them.
    assign op        = illegal_s ? NOP_INST : raw_op_s;
    assign rd        = illegal_s ? 5'd0 : raw_rd_s;
    assign rs1       = illegal_s ? 5'd0 : raw_rs1_s;
    assign rs2       = illegal_s ? 5'd0 : raw_rs2_s;
    assign imm       = illegal_s ? {DQ_XLEN{1'b0}} : raw_imm_s;
    assign is_ls     = raw_is_ls_s & ~illegal_s;
    assign is_store  = raw_is_store_s & ~illegal_s;
    assign is_branch = raw_is_branch_s & ~illegal_s;
    assign illegal   = illegal_s;

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: a DEPTH-entry FIFO of {inst, pc} feeding one
// registered decoded-output slot. DEPTH must be a power of two, >= 2.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = DQ_XLEN
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    decode_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};

    // Storage is deliberately not reset; count and pointers define validity.
    logic [XLEN-1:0]  inst_mem_r [DEPTH];
    logic [XLEN-1:0]  pc_mem_r   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic in_ready_s;
    logic flush_s;
    logic push_s;
    logic pop_s;

    op_e        dec_op_s;
    REG_ID_TYPE dec_rd_s;
    REG_ID_TYPE dec_rs1_s;
    REG_ID_TYPE dec_rs2_s;
    IMM_TYPE    dec_imm_s;
    logic       dec_is_ls_s;
    logic       dec_is_store_s;
    logic       dec_is_branch_s;
    logic       dec_illegal_s;

    logic       out_valid_r;
    op_e        out_op_r;
    REG_ID_TYPE out_rd_r;
    REG_ID_TYPE out_rs1_r;
    REG_ID_TYPE out_rs2_r;
    IMM_TYPE    out_imm_r;
    logic [XLEN-1:0] out_pc_r;
    logic       out_is_ls_r;
    logic       out_is_store_r;
    logic       out_is_branch_r;
    logic       out_illegal_r;

    // in_ready ignores flush; a push coinciding with a flush is simply dropped.
    assign in_ready_s = rdy_in & (count_r != FULL_CNT);
    assign flush_s    = rdy_in & flush_in;
    assign push_s     = bus.in_valid & in_ready_s & ~flush_in;
    assign pop_s      = rdy_in & ~flush_in & (count_r != EMPTY_CNT) &
                        (~out_valid_r | bus.out_ready);

    rv32i_decode u_decode (
        .inst      (inst_mem_r[rd_ptr_r]),
        .op        (dec_op_s),
        .rd        (dec_rd_s),
        .rs1       (dec_rs1_s),
        .rs2       (dec_rs2_s),
        .imm       (dec_imm_s),
        .is_ls     (dec_is_ls_s),
        .is_store  (dec_is_store_s),
        .is_branch (dec_is_branch_s),
        .illegal   (dec_illegal_s)
    );

    // FIFO entry write on an accepted push.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            inst_mem_r[wr_ptr_r] <= bus.in_inst;
            pc_mem_r[wr_ptr_r]   <= bus.in_pc;
        end
    end

    // Pointer and occupancy tracking; everything holds while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= EMPTY_CNT;
        end else if (flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= EMPTY_CNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Output slot: load the decoded head on pop, clear when consumed, else hold.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_valid_r     <= 1'b0;
            out_op_r        <= NOP_INST;
            out_rd_r        <= 5'd0;
            out_rs1_r       <= 5'd0;
            out_rs2_r       <= 5'd0;
            out_imm_r       <= {DQ_XLEN{1'b0}};
            out_pc_r        <= {XLEN{1'b0}};
            out_is_ls_r     <= 1'b0;
            out_is_store_r  <= 1'b0;
            out_is_branch_r <= 1'b0;
            out_illegal_r   <= 1'b0;
        end else if (flush_s) begin
            out_valid_r <= 1'b0;
        end else if (pop_s) begin
            out_valid_r     <= 1'b1;
            out_op_r        <= dec_op_s;
            out_rd_r        <= dec_rd_s;
            out_rs1_r       <= dec_rs1_s;
            out_rs2_r       <= dec_rs2_s;
            out_imm_r       <= dec_imm_s;
            out_pc_r        <= pc_mem_r[rd_ptr_r];
            out_is_ls_r     <= dec_is_ls_s;
            out_is_store_r  <= dec_is_store_s;
            out_is_branch_r <= dec_is_branch_s;
            out_illegal_r   <= dec_illegal_s;
        end else if (rdy_in & bus.out_ready & out_valid_r) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_op        = out_op_r;
    assign bus.out_rd        = out_rd_r;
    assign bus.out_rs1       = out_rs1_r;
    assign bus.out_rs2       = out_rs2_r;
    assign bus.out_imm       = out_imm_r;
    assign bus.out_pc        = out_pc_r;
    assign bus.out_is_ls     = out_is_ls_r;
    assign bus.out_is_store  = out_is_store_r;
    assign bus.out_is_branch = out_is_branch_r;
    assign bus.out_illegal   = out_illegal_r;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH = 4).
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic flush_in;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [31:0] inst;
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  flags;   // {is_ls, is_store, is_branch, illegal}
    } vec_t;

    decode_queue_if bus ();

    decode_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if ({bus.out_op, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc,
             bus.out_is_ls, bus.out_is_store, bus.out_is_branch, bus.out_illegal} !== 89'd0) begin
            n_bad++; $display("FAIL reset_outs: got op=%0d imm=%h pc=%h want all zero",
                              bus.out_op, bus.out_imm, bus.out_pc);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        rst_in = 1'b1;
        step();
    endtask

    task automatic test_decode();
        vec_t tab [6];
        logic [56:0] got_v;
        logic [56:0] exp_v;
        tab[0] = '{32'h00500093, ADDI_INST, 5'd1, 5'd0, 5'd0, 32'h0000_0005, 4'b0000};
        tab[1] = '{32'h4030D113, SRAI_INST, 5'd2, 5'd1, 5'd0, 32'h0000_0003, 4'b0000};
        tab[2] = '{32'h0020B1B3, SLTU_INST, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 4'b0000};
        tab[3] = '{32'h123452B7, LUI_INST,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 4'b0000};
        tab[4] = '{32'hFE208EE3, BEQ_INST,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 4'b0010};
        tab[5] = '{32'h0020A423, SW_INST,   5'd0, 5'd1, 5'd2, 32'h0000_0008, 4'b1100};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = tab[i].inst;
            bus.in_pc    = 32'h0000_1000 + 32'(i * 4);
            step();
            bus.in_valid = 1'b0;
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++; $display("FAIL decode_latency[%0d]: got valid=%b want 0", i, bus.out_valid);
            end
            step();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_1000 + 32'(i * 4)) begin
                n_bad++; $display("FAIL decode_valid_pc[%0d]: got valid=%b pc=%h want 1 %h",
                                  i, bus.out_valid, bus.out_pc, 32'h0000_1000 + 32'(i * 4));
            end
            got_v = {bus.out_op, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm,
                     bus.out_is_ls, bus.out_is_store, bus.out_is_branch, bus.out_illegal};
            exp_v = {tab[i].op, tab[i].rd, tab[i].rs1, tab[i].rs2, tab[i].imm, tab[i].flags};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++; $display("FAIL decode_fields[%0d]: got %h want %h", i, got_v, exp_v);
            end
        end
        step();
    endtask

    task automatic test_full();
        int  accepted;
        logic ready_seen;
        accepted = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = 32'h0000_0093 | (32'(accepted) << 20);
            bus.in_pc    = 32'(accepted) * 32'd4;
            @(negedge clk_in);
            ready_seen = bus.in_ready;
            n_cmp++;
            if (ready_seen !== (c < 5)) begin
                n_bad++; $display("FAIL full_in_ready[%0d]: got %b want %b", c, ready_seen, (c < 5));
            end
            step();
            if (ready_seen === 1'b1) accepted++;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (accepted != 5) begin
            n_bad++; $display("FAIL full_accepted: got %0d want 5", accepted);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(k * 4) || bus.out_imm !== 32'(k)) begin
                n_bad++; $display("FAIL full_drain[%0d]: got valid=%b pc=%h imm=%h want 1 %h %h",
                                  k, bus.out_valid, bus.out_pc, bus.out_imm, 32'(k * 4), 32'(k));
            end
            step();
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL full_empty: got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = 32'h00500093;
            bus.in_pc    = 32'h0000_2000 + 32'(i * 4);
            step();
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_2000) begin
            n_bad++; $display("FAIL flush_pre: got valid=%b pc=%h want 1 00002000", bus.out_valid, bus.out_pc);
        end
        bus.in_pc = 32'h0000_2FF0;
        flush_in  = 1'b1;
        step();
        flush_in     = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_clear: got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++; $display("FAIL flush_gone[%0d]: got valid=%b pc=%h want 0", i, bus.out_valid, bus.out_pc);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h0000_2100;
        step();
        bus.in_valid = 1'b0;
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_2100) begin
            n_bad++; $display("FAIL flush_after: got valid=%b pc=%h want 1 00002100", bus.out_valid, bus.out_pc);
        end
        step();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = 32'h0020B1B3;
            bus.in_pc    = 32'h0000_0300 + 32'(i * 4);
            step();
        end
        bus.in_pc = 32'h0000_030C;
        rdy_in    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_0304 ||
                bus.out_op !== SLTU_INST || bus.in_ready !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got valid=%b pc=%h op=%0d ready=%b want 1 00000304 %0d 0",
                                  i, bus.out_valid, bus.out_pc, bus.out_op, bus.in_ready, SLTU_INST);
            end
        end
        rdy_in       = 1'b1;
        bus.in_valid = 1'b0;
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_0308) begin
            n_bad++; $display("FAIL stall_resume: got valid=%b pc=%h want 1 00000308", bus.out_valid, bus.out_pc);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL stall_no_extra: got valid=%b pc=%h want 0", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] words [3];
        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'h8030_D113;
        words[2] = 32'h0050_0093;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = words[i];
            bus.in_pc    = 32'h0000_0400 + 32'(i * 4);
            step();
            bus.in_valid = 1'b0;
            step();
            if (i < 2) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_op !== NOP_INST ||
                    bus.out_rd !== 5'd0 || bus.out_rs1 !== 5'd0 || bus.out_imm !== 32'd0) begin
                    n_bad++; $display("FAIL illegal[%0d]: got valid=%b ill=%b op=%0d rd=%0d rs1=%0d imm=%h want 1 1 0 0 0 0",
                                      i, bus.out_valid, bus.out_illegal, bus.out_op, bus.out_rd, bus.out_rs1, bus.out_imm);
                end
            end else begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b0 || bus.out_op !== ADDI_INST ||
                    bus.out_rd !== 5'd1 || bus.out_imm !== 32'd5) begin
                    n_bad++; $display("FAIL illegal_recover: got valid=%b ill=%b op=%0d rd=%0d imm=%h want 1 0 %0d 1 5",
                                      bus.out_valid, bus.out_illegal, bus.out_op, bus.out_rd, bus.out_imm, ADDI_INST);
                end
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = 32'h00500093;
            bus.in_pc    = 32'h0000_0500 + 32'(i * 4);
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_pre: got valid=%b want 1", bus.out_valid);
        end
        #2;
        rst_in = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'd0) begin
            n_bad++; $display("FAIL rstmid_async: got valid=%b pc=%h want 0 00000000", bus.out_valid, bus.out_pc);
        end
        step();
        rst_in = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_ready: got %b want 1", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_empty: got valid=%b pc=%h want 0", bus.out_valid, bus.out_pc);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        flush_in      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'd0;
        bus.in_pc     = 32'd0;
        bus.out_ready = 1'b0;

        test_reset();
        test_decode();
        test_full();
        test_flush();
        test_stall();
        test_illegal();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
